// File: rtl/snake_motion_controller_if.sv
// Signal bundle between the debouncers/VGA timing (master side) and the snake
// motion controller (slave side). The outputs feed DisplayDriver.
interface snake_motion_controller_if;
    logic       FRAME_TICK;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       BTN_LEFT;
    logic       BTN_RIGHT;
    logic       START;
    logic       PAUSE;
    logic       GROW;
    logic [9:0] SnakeX;
    logic [9:0] SnakeY;
    logic [1:0] SnakeDir;
    logic [3:0] SnakeSize;
    logic       GAME_OVER;
    logic       STEP_PULSE;

    modport master (
        output FRAME_TICK, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, START, PAUSE, GROW,
        input  SnakeX, SnakeY, SnakeDir, SnakeSize, GAME_OVER, STEP_PULSE
    );

    modport slave (
        input  FRAME_TICK, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, START, PAUSE, GROW,
        output SnakeX, SnakeY, SnakeDir, SnakeSize, GAME_OVER, STEP_PULSE
    );
endinterface

// File: rtl/snake_motion_controller.sv
// Snake head sequencer: direction requests, frame-paced stepping, 640x480 bounds
// and the IDLE/RUN/OVER game FSM. Define SNAKE_WRAP_EN to make walls wrap.
module snake_motion_controller #(
    parameter logic [9:0] STEP            = 10'd10,
    parameter logic [5:0] FRAMES_PER_STEP = 6'd4,
    parameter logic [9:0] START_X         = 10'd320,
    parameter logic [9:0] START_Y         = 10'd240
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    snake_motion_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    localparam logic [1:0]  DIR_RIGHT = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_UP    = 2'd3;
    localparam logic [10:0] X_MAX     = 11'd639;
    localparam logic [10:0] Y_MAX     = 11'd479;
    localparam logic [10:0] X_SPAN    = 11'd640;
    localparam logic [10:0] Y_SPAN    = 11'd480;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  dir_q, dir_d, pend_q, pend_d;
    logic [3:0]  size_q, size_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        over_q, over_d, step_q, step_d;

    logic        req_valid;
    logic [1:0]  req_dir, eff_pend;
    logic [10:0] nx, ny, step_w;
    logic        hit;

    assign step_w = {1'b0, STEP};

    // Simultaneous buttons resolve UP > DOWN > LEFT > RIGHT
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if (bus.BTN_UP)         req_dir = DIR_UP;
        else if (bus.BTN_DOWN)  req_dir = DIR_DOWN;
        else if (bus.BTN_LEFT)  req_dir = DIR_LEFT;
        else if (bus.BTN_RIGHT) req_dir = DIR_RIGHT;
        else                    req_valid = 1'b0;
    end

    // Candidate head for the direction that a step taken this cycle would use
    always_comb begin
        eff_pend = pend_q;
        if (req_valid && state_q != OVER && req_dir != (dir_q ^ 2'b10))
            eff_pend = req_dir;
        nx  = {1'b0, x_q};
        ny  = {1'b0, y_q};
        hit = 1'b0;
        case (eff_pend)
            DIR_RIGHT: begin
                nx  = {1'b0, x_q} + step_w;
                hit = nx > X_MAX;
`ifdef SNAKE_WRAP_EN
                if (hit) nx = nx - X_SPAN;
`endif
            end
            DIR_LEFT: begin
                nx  = {1'b0, x_q} - step_w;
                hit = {1'b0, x_q} < step_w;
`ifdef SNAKE_WRAP_EN
                if (hit) nx = {1'b0, x_q} + X_SPAN - step_w;
`endif
            end
            DIR_DOWN: begin
                ny  = {1'b0, y_q} + step_w;
                hit = ny > Y_MAX;
`ifdef SNAKE_WRAP_EN
                if (hit) ny = ny - Y_SPAN;
`endif
            end
            default: begin
                ny  = {1'b0, y_q} - step_w;
                hit = {1'b0, y_q} < step_w;
`ifdef SNAKE_WRAP_EN
                if (hit) ny = {1'b0, y_q} + Y_SPAN - step_w;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        over_d  = over_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = eff_pend;
                if (bus.START) state_d = RUN;
            end
            RUN: begin
                pend_d = eff_pend;
                if (bus.GROW && size_q != 4'd15) size_d = size_q + 4'd1;
                if (bus.FRAME_TICK && !bus.PAUSE) begin
                    if (cnt_q == FRAMES_PER_STEP - 6'd1) begin
                        cnt_d = 6'd0;
`ifdef SNAKE_WRAP_EN
                        x_d    = nx[9:0];
                        y_d    = ny[9:0];
                        dir_d  = eff_pend;
                        step_d = 1'b1;
`else
                        if (hit) begin
                            state_d = OVER;
                            over_d  = 1'b1;
                        end else begin
                            x_d    = nx[9:0];
                            y_d    = ny[9:0];
                            dir_d  = eff_pend;
                            step_d = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            OVER: begin
                // Restart takes precedence over any tick arriving with it
                if (bus.START) begin
                    state_d = RUN;
                    x_d     = START_X;
                    y_d     = START_Y;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                    size_d  = 4'd1;
                    cnt_d   = 6'd0;
                    over_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            size_q  <= 4'd1;
            cnt_q   <= 6'd0;
            over_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            step_q  <= step_d;
        end
    end

    assign bus.SnakeX     = x_q;
    assign bus.SnakeY     = y_q;
    assign bus.SnakeDir   = dir_q;
    assign bus.SnakeSize  = size_q;
    assign bus.GAME_OVER  = over_q;
    assign bus.STEP_PULSE = step_q;
endmodule

// File: doc/snake_motion_controller.md
# snake_motion_controller

- Sequences the snake head state consumed by `DisplayDriver`: position (`SnakeX`, `SnakeY`), direction (`SnakeDir`) and length (`SnakeSize`).
- Accepts direction requests, advances the head once every N frames, enforces the 640x480 playfield bounds and runs the game state machine (idle / run / over).
- Sits between the button debouncers and `DisplayDriver`; the frame tick comes from the VGA timing generator.

## Interface
Parameters:
- `STEP`, 10'd10, pixels moved per step.
- `FRAMES_PER_STEP`, 6'd4, frame ticks per step; legal range 1..63.
- `START_X`, 10'd320, head X after reset/restart.
- `START_Y`, 10'd240, head Y after reset/restart.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `FRAME_TICK`  in  1  one-cycle pulse per displayed frame.
- `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`  in  1 each  debounced single-cycle request pulses.
- `START`  in  1  single-cycle start/restart pulse.
- `PAUSE`  in  1  level; freezes movement while high.
- `GROW`  in  1  single-cycle pulse; lengthens snake by one.
- `SnakeX`  out  10  head X (0..639).
- `SnakeY`  out  10  head Y (0..479).
- `SnakeDir`  out  2  RIGHT=00, DOWN=01, LEFT=10, UP=11.
- `SnakeSize`  out  4  length, saturating.
- `GAME_OVER`  out  1  high while in OVER.
- `STEP_PULSE`  out  1  one-cycle pulse when a move is committed.

## Operation
- States: IDLE, RUN, OVER. Reset enters IDLE.
- IDLE -> RUN on `START`. RUN -> OVER on collision. OVER -> RUN on `START`; the restart also reloads all start values.
- Start values: X=`START_X`, Y=`START_Y`, Dir=RIGHT, Size=1, frame counter=0, pending dir=RIGHT.
- Direction request:
  - Accepted in IDLE and RUN; ignored in OVER.
  - If several buttons pulse in one cycle, priority is UP > DOWN > LEFT > RIGHT.
  - A request equal to `SnakeDir ^ 2'b10` (reversal) is discarded.
  - An accepted request is stored in a pending register; a later request overwrites it. Reversal is checked against the committed `SnakeDir`, not the pending value.
- Frame counter:
  - In RUN with `PAUSE` low, each `FRAME_TICK` increments the counter.
  - When the counter equals `FRAMES_PER_STEP-1` on a tick, a step occurs and the counter clears.
  - With `PAUSE` high, ticks are ignored and the counter holds.
- Step:
  - Dir := pending.
  - Next head = current ± `STEP` on one axis, per the new direction.
  - Arithmetic is in 11 bits to detect over/underflow.
- Collision:
  - RIGHT: X+STEP > 639. LEFT: X < STEP. DOWN: Y+STEP > 479. UP: Y < STEP.
  - On collision: position and Dir hold their pre-step values, state -> OVER, `STEP_PULSE` stays low.
- `GROW` in RUN: `SnakeSize` +1, saturating at 15. Ignored in IDLE and OVER.
- `STEP_PULSE` is high for one cycle on each committed (non-colliding) step.

## Timing
- Reset values: `SnakeX`=`START_X`, `SnakeY`=`START_Y`, `SnakeDir`=00, `SnakeSize`=1, `GAME_OVER`=0, `STEP_PULSE`=0.
- All outputs are registered.
- Step latency: outputs and `STEP_PULSE` update on the clock edge after the sampled terminal `FRAME_TICK` (1 cycle).
- A button pulse in the same cycle as the step tick is applied to that step.
- `START` coincident with a step tick in OVER: the restart wins and no step occurs.
- `GAME_OVER` rises one cycle after the colliding tick.
- `GROW` coincident with a step: both take effect.
- `RST_N` asserted mid-step: outputs go to reset values immediately; the pending request is lost.

## Configuration
- `SNAKE_WRAP_EN` defined: walls wrap instead of colliding; OVER is unreachable.
  - RIGHT overflow: X := X+STEP-640.
  - LEFT underflow: X := X+640-STEP.
  - Y wraps likewise modulo 480.
- Undefined: collision-to-OVER behaviour as specified above.

## Test plan
- Reset, then `START`, then 4 `FRAME_TICK`s -> `STEP_PULSE` once; `SnakeX`=330, `SnakeY`=240, `SnakeDir`=00.
- In RUN going RIGHT, pulse `BTN_LEFT`, then `BTN_UP` -> LEFT discarded; next step gives Dir=11, Y=230, X unchanged.
- Start at X=630 going RIGHT, one step -> `GAME_OVER`=1, X stays 630, no `STEP_PULSE`. Then `START` -> X=320, Y=240, Dir=00, Size=1, `GAME_OVER`=0.
- `PAUSE` high across 10 ticks -> no change. `PAUSE` low, 4 ticks -> exactly one step.
- 20 `GROW` pulses in RUN -> `SnakeSize`=15 (saturated). `GROW` in IDLE -> unchanged.
- With `SNAKE_WRAP_EN`, X=635 going RIGHT, one step -> X=5, `GAME_OVER`=0.
